// File: rtl/dmem_responder.sv
// Data-memory responder for the rv32 load/store port: same-cycle loads, byte-lane
// masked stores, and a small MMIO window (cycle counter, TOHOST mailbox, HALT flag).
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWE,
    input  logic [2:0]  memcontrol,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        misaligned,
    output logic [31:0] tohost,
    output logic        tohost_valid,
    output logic        halt
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] OFF_CYCLE_LO = 32'h0000_0000;
    localparam logic [31:0] OFF_CYCLE_HI = 32'h0000_0004;
    localparam logic [31:0] OFF_TOHOST   = 32'h0000_0008;
    localparam logic [31:0] OFF_HALT     = 32'h0000_000C;

    logic [31:0]   mem_r [DEPTH_WORDS];
    logic [63:0]   cycle_r;
    logic [31:0]   tohost_r;
    logic          tohost_valid_r;
    logic          halt_r;

    logic [AW-1:0] idx_s;
    logic [31:0]   offset_s;
    logic [31:0]   word_s;
    logic [31:0]   mmio_rdata_s;
    logic [31:0]   rdata_s;
    logic          is_mmio_s;
    logic          is_word_s;
    logic          misaligned_s;
    logic          reserved_s;
    logic          access_ok_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;
    logic          ram_we_s;
    logic          mmio_we_s;
    logic          tohost_we_s;
    logic          halt_set_s;

    // Pick the addressed lane out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h00_0000, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0000, h};
            F3_W:    r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Address decode, alignment and reserved-size classification.
    always_comb begin
        idx_s        = addr[AW+1:2];
        offset_s     = addr - MMIO_BASE;
        is_mmio_s    = (addr >= MMIO_BASE);
        is_word_s    = (memcontrol == F3_W);
        word_s       = mem_r[idx_s];
        misaligned_s = 1'b0;
        reserved_s   = 1'b0;
        case (memcontrol)
            F3_B, F3_BU: misaligned_s = 1'b0;
            F3_H, F3_HU: misaligned_s = addr[0];
            F3_W:        misaligned_s = (addr[1:0] != 2'b00);
            default:     reserved_s   = 1'b1;
        endcase
        access_ok_s = !misaligned_s && !reserved_s;
    end

    // Register-window read mux; only exact word offsets are populated.
    always_comb begin
        mmio_rdata_s = 32'h0000_0000;
        case (offset_s)
            OFF_CYCLE_LO: mmio_rdata_s = cycle_r[31:0];
            OFF_CYCLE_HI: mmio_rdata_s = cycle_r[63:32];
            OFF_TOHOST:   mmio_rdata_s = tohost_r;
            OFF_HALT:     mmio_rdata_s = {31'h0000_0000, halt_r};
            default:      mmio_rdata_s = 32'h0000_0000;
        endcase
    end

    // Load data: zero for bad accesses, window reads are word-only.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (!access_ok_s) begin
            rdata_s = 32'h0000_0000;
        end else if (is_mmio_s) begin
            rdata_s = is_word_s ? mmio_rdata_s : 32'h0000_0000;
        end else begin
            rdata_s = load_extend(word_s, addr[1:0], memcontrol);
        end
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        case (memcontrol)
            F3_B, F3_BU: begin
                be_s    = 4'b0001 << addr[1:0];
                wdata_s = {4{writedata[7:0]}};
            end
            F3_H, F3_HU: begin
                be_s    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{writedata[15:0]}};
            end
            F3_W: begin
                be_s    = 4'b1111;
                wdata_s = writedata;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Store qualification; a raised halt blocks every store.
    always_comb begin
        ram_we_s    = memWE && access_ok_s && !is_mmio_s && !halt_r;
        mmio_we_s   = memWE && access_ok_s && is_mmio_s && is_word_s && !halt_r;
        tohost_we_s = mmio_we_s && (offset_s == OFF_TOHOST);
        halt_set_s  = mmio_we_s && (offset_s == OFF_HALT) && (writedata != 32'h0000_0000);
    end

    // RAM byte-lane writes; contents survive reset and a store during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Cycle counter, TOHOST mailbox and sticky halt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_r        <= 64'h0000_0000_0000_0000;
            tohost_r       <= 32'h0000_0000;
            tohost_valid_r <= 1'b0;
            halt_r         <= 1'b0;
        end else begin
            if (!halt_r) begin
                cycle_r <= cycle_r + 64'h0000_0000_0000_0001;
            end
            tohost_valid_r <= tohost_we_s;
            if (tohost_we_s) begin
                tohost_r <= writedata;
            end
            if (halt_set_s) begin
                halt_r <= 1'b1;
            end
        end
    end

    assign readdata     = rdata_s;
    assign misaligned   = misaligned_s;
    assign tohost       = tohost_r;
    assign tohost_valid = tohost_valid_r;
    assign halt         = halt_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed test-plan vectors plus random traffic
// checked against a byte-addressed behavioural model.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned MEMB  = 4 * DEPTH;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [2:0]  FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        memWE;
    logic [2:0]  memcontrol;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        misaligned;
    logic [31:0] tohost;
    logic        tohost_valid;
    logic        halt;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .memWE(memWE), .memcontrol(memcontrol),
        .addr(addr), .writedata(writedata), .readdata(readdata),
        .misaligned(misaligned), .tohost(tohost), .tohost_valid(tohost_valid),
        .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
        logic [31:0] th;
        logic        tv;
        logic        hl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [7:0]  m_mem [MEMB];
    logic [63:0] m_cnt;
    logic [31:0] m_th;
    logic        m_tv;
    logic        m_halt;

    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic m_misal(input logic [31:0] a, input logic [2:0] f3);
        int s = acc_size(f3);
        return (s > 1) && ((int'(a[1:0]) % s) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
        int s = acc_size(f3);
        int b;
        logic [31:0] v = 32'h0;
        if (s == 0 || m_misal(a, f3)) return 32'h0;
        if (a >= BASE) begin
            if (s != 4) return 32'h0;
            case (a - BASE)
                32'h0:   return m_cnt[31:0];
                32'h4:   return m_cnt[63:32];
                32'h8:   return m_th;
                32'hC:   return {31'h0, m_halt};
                default: return 32'h0;
            endcase
        end
        b = int'(a % MEMB);
        for (int k = 0; k < s; k++) v = v | (32'(m_mem[b + k]) << (8 * k));
        if (f3 == FB && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == FH && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_reset();
        m_cnt  = 64'h0;
        m_th   = 32'h0;
        m_tv   = 1'b0;
        m_halt = 1'b0;
    endtask

    // One access for one clock cycle: push expectation, advance the model, pass the edge.
    task automatic step(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit chk, input bit use_c,
                        input logic [31:0] c_rd, input string nm);
        exp_t e;
        int   s;
        logic th_st = 1'b0;
        logic hl_st = 1'b0;
        memWE = we; memcontrol = f3; addr = a; writedata = wd;
        e.rd  = use_c ? c_rd : m_load(a, f3);
        e.mis = m_misal(a, f3);
        e.th  = m_th;
        e.tv  = m_tv;
        e.hl  = m_halt;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        if (reset) begin
            s = acc_size(f3);
            if (we && !m_halt && s != 0 && !m_misal(a, f3)) begin
                if (a >= BASE) begin
                    if (s == 4 && (a - BASE) == 32'h8) begin
                        m_th  = wd;
                        th_st = 1'b1;
                    end
                    if (s == 4 && (a - BASE) == 32'hC && wd != 32'h0) hl_st = 1'b1;
                end else begin
                    for (int k = 0; k < s; k++) m_mem[int'(a % MEMB) + k] = wd[8*k +: 8];
                end
            end
            if (!m_halt) m_cnt = m_cnt + 64'h1;
            m_tv = th_st;
            if (hl_st) m_halt = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s %s actual=%08h expected=%08h", nm, fld, act, expv);
        end
    endtask

    exp_t  mon_e;
    string mon_n;

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            cmp(mon_n, "readdata", readdata, mon_e.rd);
            cmp(mon_n, "misaligned", {31'h0, misaligned}, {31'h0, mon_e.mis});
            cmp(mon_n, "tohost", tohost, mon_e.th);
            cmp(mon_n, "tohost_valid", {31'h0, tohost_valid}, {31'h0, mon_e.tv});
            cmp(mon_n, "halt", {31'h0, halt}, {31'h0, mon_e.hl});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd;
        logic [2:0]  f3;
        reset = 1'b0; memWE = 1'b0; memcontrol = FW; addr = 32'h0; writedata = 32'h0;
        model_reset();
        for (int i = 0; i < MEMB; i++) m_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int w = 0; w < DEPTH; w++) step(1'b1, FW, 32'(w * 4), 32'h0, 1'b0, 1'b0, 32'h0, "fill");

        // reset mid-run, then count 10 cycles
        reset = 1'b0;
        model_reset();
        step(1'b0, FW, BASE, 32'h0, 1'b1, 1'b1, 32'h0, "reset_cycle_lo");
        reset = 1'b1;
        repeat (10) step(1'b0, FW, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "idle");
        step(1'b0, FW, BASE, 32'h0, 1'b1, 1'b1, 32'd10, "cycle_lo_10");

        // byte/half extension
        step(1'b1, FW, 32'h100, 32'h80FF_7F01, 1'b0, 1'b0, 32'h0, "sw100");
        step(1'b0, FB,  32'h100, 32'h0, 1'b1, 1'b1, 32'h0000_0001, "lb100");
        step(1'b0, FB,  32'h103, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF80, "lb103");
        step(1'b0, FBU, 32'h103, 32'h0, 1'b1, 1'b1, 32'h0000_0080, "lbu103");
        step(1'b0, FH,  32'h102, 32'h0, 1'b1, 1'b1, 32'hFFFF_80FF, "lh102");
        step(1'b0, FHU, 32'h102, 32'h0, 1'b1, 1'b1, 32'h0000_80FF, "lhu102");

        // lane masking
        step(1'b1, FW, 32'h200, 32'h1122_3344, 1'b0, 1'b0, 32'h0, "sw200");
        step(1'b1, FB, 32'h201, 32'h0000_00AB, 1'b0, 1'b0, 32'h0, "sb201");
        step(1'b1, FH, 32'h202, 32'h0000_CDEF, 1'b0, 1'b0, 32'h0, "sh202");
        step(1'b0, FW, 32'h200, 32'h0, 1'b1, 1'b1, 32'hCDEF_AB44, "lw200");

        // misalignment and reserved sizes
        step(1'b1, FW, 32'h205, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, "sw205_mis");
        step(1'b0, FW, 32'h204, 32'h0, 1'b1, 1'b1, 32'h0, "lw204");
        step(1'b0, FH, 32'h201, 32'h0, 1'b1, 1'b1, 32'h0, "lh201_mis");
        step(1'b0, 3'b011, 32'h200, 32'h0, 1'b1, 1'b1, 32'h0, "reserved011");

        // same-cycle store/load and aliasing
        step(1'b1, FW, 32'h300, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0, "sw300_same");
        step(1'b0, FW, 32'h300, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, "lw300");
        step(1'b0, FW, 32'h300 + MEMB, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, "lw300_alias");

        // TOHOST mailbox
        step(1'b1, FW, BASE + 32'h8, 32'd5, 1'b1, 1'b0, 32'h0, "tohost5");
        step(1'b1, FW, BASE + 32'h8, 32'd7, 1'b1, 1'b0, 32'h0, "tohost7");
        step(1'b0, FW, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "tohost_after1");
        step(1'b1, FB, BASE + 32'h8, 32'd9, 1'b1, 1'b0, 32'h0, "tohost_sb");
        step(1'b0, FW, BASE + 32'h8, 32'h0, 1'b1, 1'b1, 32'd7, "tohost_rd");

        // random traffic (HALT stores only ever write zero here)
        for (int n = 0; n < 400; n++) begin
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = BASE + 32'($urandom_range(0, 19));
                if ((a - BASE) >= 32'd12 && (a - BASE) <= 32'd15) wd = 32'h0;
            end else begin
                a = 32'($urandom_range(0, 511)) + 32'(MEMB * $urandom_range(0, 3));
            end
            step(1'($urandom_range(0, 1)), f3, a, wd, 1'b1, 1'b0, 32'h0, "random");
        end

        // halt: zero store ignored, nonzero freezes counter and blocks stores
        step(1'b1, FW, BASE + 32'hC, 32'h0, 1'b1, 1'b0, 32'h0, "halt_zero");
        step(1'b1, FW, BASE + 32'hC, 32'h1, 1'b1, 1'b0, 32'h0, "halt_set");
        step(1'b0, FW, BASE, 32'h0, 1'b1, 1'b0, 32'h0, "cycle_frozen1");
        step(1'b0, FW, BASE, 32'h0, 1'b1, 1'b0, 32'h0, "cycle_frozen2");
        step(1'b0, FW, BASE + 32'hC, 32'h0, 1'b1, 1'b1, 32'h1, "halt_rd");
        step(1'b1, FW, 32'h300, 32'h1234_5678, 1'b1, 1'b0, 32'h0, "sw_halted");
        step(1'b0, FW, 32'h300, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, "lw_halted");
        step(1'b1, FW, BASE + 32'h8, 32'h55, 1'b1, 1'b0, 32'h0, "tohost_halted");

        // async reset while halted; store during reset is discarded
        reset = 1'b0;
        model_reset();
        step(1'b1, FW, 32'h300, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hDEAD_BEEF, "reset_store");
        reset = 1'b1;
        step(1'b0, FW, 32'h300, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, "after_reset_lw");
        step(1'b0, FW, BASE + 32'hC, 32'h0, 1'b1, 1'b1, 32'h0, "after_reset_halt");
        step(1'b0, FW, BASE, 32'h0, 1'b1, 1'b0, 32'h0, "after_reset_cycle");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the rv32 core's load/store port. It receives the core's memory request (address, write enable, funct3-encoded size/sign control, store data) and returns load data in the same cycle. Stores are applied with byte-lane masking on the clock edge. It also decodes a small memory-mapped register window: a free-running 64-bit cycle counter, a TOHOST mailbox and a sticky HALT flag used by simulation benches.

## Interface
Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two).
- MMIO_BASE, 32'hFFFF_0000, base address of the register window (64 KiB aligned).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memWE  in  1  store request this cycle.
- memcontrol  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address (core's aluout).
- writedata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- readdata  out  32  load data, extended per memcontrol.
- misaligned  out  1  current access is misaligned (combinational).
- tohost  out  32  last value stored to TOHOST.
- tohost_valid  out  1  one-cycle pulse after each TOHOST store.
- halt  out  1  sticky; set by a nonzero store to HALT.

## Operation
- Decode: addr >= MMIO_BASE selects the register window; otherwise RAM at word index addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so RAM aliases modulo 4*DEPTH_WORDS bytes.
- Alignment: an H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, sets misaligned=1. That access returns readdata=0, and a store is suppressed.
- Reserved memcontrol (011, 110, 111): readdata=0, store suppressed, misaligned=0.
- Loads from RAM: select byte lane addr[1:0] or half lane addr[1]. B/H sign-extend; BU/HU zero-extend; W is returned unchanged.
- Stores to RAM: SB writes only lane addr[1:0] with writedata[7:0]. SH writes lanes {addr[1],0} and {addr[1],1} with writedata[15:0]. SW writes all 4 lanes. Other lanes are untouched.
- Register window: word accesses only. A non-W access inside the window returns 0 and ignores the store.
  - offset 0x0 CYCLE_LO (RO), 0x4 CYCLE_HI (RO).
  - offset 0x8 TOHOST (RW): read returns tohost.
  - offset 0xC HALT (RW): read returns {31'b0, halt}.
  - Other offsets read 0; stores to them are ignored.
  - Stores to CYCLE_LO and CYCLE_HI are ignored.
- Cycle counter: 64-bit, increments by 1 every clk while halt=0, wraps 2^64-1 -> 0, freezes once halt=1.
- halt=1: all stores, to both RAM and the register window, are ignored. Loads still work.

## Timing
- readdata and misaligned are purely combinational from addr, memcontrol and current state. Zero-cycle load latency.
- Stores commit at the rising edge ending the cycle in which memWE=1. A load in that same cycle returns the pre-store contents. A load in the next cycle returns the new value.
- TOHOST store at edge N: tohost updates at N, and tohost_valid=1 for cycle N..N+1. Back-to-back TOHOST stores hold tohost_valid high and update tohost every edge.
- HALT nonzero store at edge N: halt=1 from N, and the counter value latched at N is held. A zero store to HALT has no effect.
- Reset assertion (async, any time):
  - cycle counter = 0, tohost = 0, tohost_valid = 0, halt = 0 immediately.
  - RAM contents are not cleared.
  - A store coinciding with the reset edge is discarded.
- Reset values of outputs: tohost=0, tohost_valid=0, halt=0. readdata and misaligned follow the combinational decode of the current inputs.

## Test plan
- Byte/half extension: SW 0x80FF_7F01 to 0x100, then:
  - LB 0x100 -> 0x0000_0001; LB 0x103 -> 0xFFFF_FF80; LBU 0x103 -> 0x0000_0080.
  - LH 0x102 -> 0xFFFF_80FF; LHU 0x102 -> 0x0000_80FF.
- Lane masking: SW 0x1122_3344 to 0x200, then SB 0xAB to 0x201, then SH 0xCDEF to 0x202. LW 0x200 -> 0xCDEF_AB44.
- Misalignment: SW to 0x205 -> misaligned=1 and 0x204 unchanged. LH 0x201 -> readdata=0, misaligned=1. Reserved memcontrol 011 -> readdata=0, misaligned=0.
- Same-cycle store/load: SW 0xDEAD_BEEF to 0x300 over 0x0 contents. Same-cycle readdata=0, next cycle 0xDEAD_BEEF. Address 0x300+4*DEPTH_WORDS aliases to the same word.
- Counter and halt: release reset and run 10 cycles -> CYCLE_LO=10. Then:
  - store 1 to HALT -> halt=1 and CYCLE_LO frozen.
  - subsequent SW to RAM ignored.
  - assert reset mid-run -> counter 0 and halt 0 immediately.
- TOHOST: two consecutive stores 5 and 7 -> tohost_valid high for 2 cycles, tohost=5 then 7, and tohost_valid low on the following cycle. A byte store to TOHOST is ignored.
